// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: state encoding, data width and
//                bit-period helper used by uart_tx and uart_rx.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef logic [1:0] uart_state_t;

    localparam uart_state_t c_ST_IDLE  = 2'd0;
    localparam uart_state_t c_ST_START = 2'd1;
    localparam uart_state_t c_ST_DATA  = 2'd2;
    localparam uart_state_t c_ST_STOP  = 2'd3;

    // Clock cycles per serial bit; integer division truncates the fraction.
    function automatic int calc_bit_clks(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

`default_nettype wire

// File: rtl/baud_tick_gen.sv
// ============================================================================
//  Module      : baud_tick_gen
//  Description : Bit-period counter; pulses tick on the last cycle of each
//                BIT_CLKS-long bit while enabled.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module baud_tick_gen #(
    parameter int BIT_CLKS = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(BIT_CLKS - 1);

    logic [CNT_W-1:0] r_cnt;

    assign tick = enable && (r_cnt == c_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clear || !enable || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
//  Module      : uart_tx
//  Description : 8N1 UART transmitter; one byte per tx_start request, LSB
//                first, registered glitch-free serial output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int BIT_CLKS  = calc_bit_clks(CLK_FREQ, BAUD_RATE)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tx_start,
    input  logic [UART_DATA_BITS-1:0] tx_data,
    output logic                      tx_busy,
    output logic                      tx_done,
    output logic                      tx
);

    localparam logic [2:0] c_LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_state_t               r_state, w_state_next;
    logic [UART_DATA_BITS-1:0] r_shift, w_shift_next;
    logic [2:0]                r_bit_idx, w_bit_idx_next;
    logic                      r_tx, w_tx_next;
    logic                      r_busy, w_busy_next;
    logic                      r_done, w_done_next;
    logic                      w_accept;
    logic                      w_baud_en;
    logic                      w_tick;

    assign w_accept  = (r_state == c_ST_IDLE) && tx_start;
    assign w_baud_en = (r_state != c_ST_IDLE);

    baud_tick_gen #(
        .BIT_CLKS (BIT_CLKS)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_accept),
        .enable (w_baud_en),
        .tick   (w_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_ST_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_idx <= w_bit_idx_next;
            r_tx      <= w_tx_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
        end
    end

    // Outputs are computed from the next state so tx/busy/done change on the
    // same edge as the state they describe.
    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_idx_next = r_bit_idx;
        w_tx_next      = r_tx;
        w_done_next    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_tx_next = 1'b1;
                if (tx_start) begin
                    w_shift_next = tx_data;
                    w_state_next = c_ST_START;
                    w_tx_next    = 1'b0;
                end
            end
            c_ST_START: begin
                if (w_tick) begin
                    w_state_next   = c_ST_DATA;
                    w_bit_idx_next = '0;
                    w_tx_next      = r_shift[0];
                end
            end
            c_ST_DATA: begin
                if (w_tick) begin
                    w_shift_next = r_shift >> 1;
                    if (r_bit_idx == c_LAST_BIT) begin
                        w_state_next = c_ST_STOP;
                        w_tx_next    = 1'b1;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                        w_tx_next      = r_shift[1];
                    end
                end
            end
            c_ST_STOP: begin
                if (w_tick) begin
                    w_state_next = c_ST_IDLE;
                    w_done_next  = 1'b1;
                    w_tx_next    = 1'b1;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
        w_busy_next = (w_state_next != c_ST_IDLE);
    end

    assign tx      = r_tx;
    assign tx_busy = r_busy;
    assign tx_done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Directed self-checking bench for uart_tx at BIT_CLKS = 10.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx;

    localparam int CLK_FREQ  = 1_000_000;
    localparam int BAUD_RATE = 100_000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_busy;
    logic       tx_done;
    logic       tx;

    int n_vec  = 0;
    int n_fail = 0;

    logic [255:0] txv, busyv, donev;

    uart_tx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .tx       (tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Request one byte from idle; returns in cycle 1 of the frame.
    task automatic start(input logic [7:0] d);
        tx_data  = d;
        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
    endtask

    // Record n cycles of outputs; index i holds frame cycle i+1.
    task automatic capture(input int n);
        txv = '0; busyv = '0; donev = '0;
        for (int i = 0; i < n; i++) begin
            txv[i]   = tx;
            busyv[i] = tx_busy;
            donev[i] = tx_done;
            step();
        end
    endtask

    // Expected 100-cycle waveform: start, 8 data LSB first, stop, 10 cycles each.
    function automatic logic [99:0] frame_bits(input logic [7:0] d);
        logic [9:0]  f;
        logic [99:0] r;
        f = {1'b1, d, 1'b0};
        for (int c = 0; c < 100; c++) r[c] = f[c / 10];
        return r;
    endfunction

    // Sample the middle of each of the ten bit slots starting at off.
    function automatic logic [9:0] mid_bits(input logic [255:0] v, input int off);
        logic [9:0] r;
        for (int k = 0; k < 10; k++) r[k] = v[off + 5 + 10 * k];
        return r;
    endfunction

    initial begin
        int rises;
        logic prev;
        logic [7:0] d;

        // Reset holds idle even with a request pending.
        tx_start = 1'b1;
        tx_data  = 8'h5A;
        step();
        check("reset_outputs", 256'({tx, tx_busy, tx_done}), 256'(3'b100));
        step();
        check("reset_ignores_start", 256'({tx, tx_busy, tx_done}), 256'(3'b100));
        tx_start = 1'b0;
        rst      = 1'b1;
        step();
        check("idle_after_release", 256'({tx, tx_busy, tx_done}), 256'(3'b100));

        // 0x31
        start(8'h31);
        capture(102);
        check("t31_bits", 256'(mid_bits(txv, 0)), 256'(10'b1001100010));
        check("t31_tx", txv, 256'({2'b11, frame_bits(8'h31)}));
        check("t31_busy", busyv, 256'({100{1'b1}}));
        check("t31_done", donev, 256'(1) << 100);

        // 0x00 then 0xFF
        start(8'h00);
        capture(100);
        check("t00_tx", txv, 256'({{10{1'b1}}, {90{1'b0}}}));
        check("t00_done", 256'(tx_done), 256'(1));
        start(8'hFF);
        capture(100);
        check("tFF_tx", txv, 256'({{90{1'b1}}, {10{1'b0}}}));
        check("tFF_done", 256'(tx_done), 256'(1));
        step();

        // 0x3C with a 0xA5 request arriving mid-frame
        start(8'h3C);
        txv = '0; busyv = '0; donev = '0;
        rises = 0;
        prev  = 1'b0;
        for (int i = 0; i < 110; i++) begin
            txv[i]   = tx;
            busyv[i] = tx_busy;
            donev[i] = tx_done;
            if (tx_busy && !prev) rises++;
            prev = tx_busy;
            if (i == 39) begin
                tx_start = 1'b1;
                tx_data  = 8'hA5;
            end else if (i == 40) begin
                tx_start = 1'b0;
                tx_data  = 8'hFF;
            end
            step();
        end
        check("t3C_bits", 256'(mid_bits(txv, 0)), 256'(10'b1001111000));
        check("t3C_tx", txv, 256'({{10{1'b1}}, frame_bits(8'h3C)}));
        check("t3C_busy", busyv, 256'({100{1'b1}}));
        check("t3C_done", donev, 256'(1) << 100);
        check("t3C_busy_rises", 256'(rises), 256'(1));

        // Back-to-back 0x55, 0xAA with tx_start held
        tx_data  = 8'h55;
        tx_start = 1'b1;
        step();
        tx_data = 8'hAA;
        txv = '0; busyv = '0; donev = '0;
        for (int i = 0; i < 202; i++) begin
            txv[i]   = tx;
            busyv[i] = tx_busy;
            donev[i] = tx_done;
            if (i == 150) tx_start = 1'b0;
            step();
        end
        check("b2b_bits_55", 256'(mid_bits(txv, 0)), 256'(10'b1010101010));
        check("b2b_bits_AA", 256'(mid_bits(txv, 101)), 256'(10'b1101010100));
        check("b2b_gap", 256'(txv[101:99]), 256'(3'b011));
        check("b2b_tx", txv, 256'({1'b1, frame_bits(8'hAA), 1'b1, frame_bits(8'h55)}));
        check("b2b_busy", busyv, 256'({1'b0, {100{1'b1}}, 1'b0, {100{1'b1}}}));
        check("b2b_done", donev, (256'(1) << 201) | (256'(1) << 100));

        // Reset at cycle 35 of a 0x31 frame
        start(8'h31);
        for (int i = 0; i < 34; i++) step();
        check("abort_pre", 256'({tx, tx_busy}), 256'(2'b01));
        rst = 1'b0;
        #1;
        check("abort_outputs", 256'({tx, tx_busy, tx_done}), 256'(3'b100));
        step();
        check("abort_hold", 256'({tx, tx_busy, tx_done}), 256'(3'b100));
        rst = 1'b1;
        start(8'h31);
        capture(102);
        check("abort_resend_tx", txv, 256'({2'b11, frame_bits(8'h31)}));
        check("abort_resend_done", donev, 256'(1) << 100);

        // Decode 256 random bytes from the line at mid-bit
        for (int n = 0; n < 256; n++) begin
            d = 8'($urandom_range(0, 255));
            start(d);
            capture(100);
            check("loopback", 256'(mid_bits(txv, 0)), 256'({1'b1, d, 1'b0}));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
